// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: FSM states, grant selection and default widths.
package mem_arb_pkg;

  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_MEM_LAT    = 4;
  localparam int DEF_STARVE_MAX = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2,
    HALTED  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_DM   = 2'd2
  } gnt_t;

  // Data wins unless fetch is waiting and has already been passed over too often.
  function automatic gnt_t arb_pick(input logic if_req, input logic dm_req,
                                    input logic starve_ok);
    gnt_t g;
    g = GNT_NONE;
    if (dm_req && (starve_ok || !if_req)) g = GNT_DM;
    else if (if_req)                      g = GNT_IF;
    return g;
  endfunction

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// Memory latency counter: cleared by load, advanced by en, tc flags count == MEM_LAT.
module mem_arb_lat_cnt #(
  parameter int MEM_LAT = 4,
  parameter int CNT_W   = $clog2(MEM_LAT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == CNT_W'(MEM_LAT));

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one fixed-latency memory between instruction fetch and data accesses.
// Optional build macro ALIGN_CHK_EN rejects odd data addresses with dm_err instead of accessing memory.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              dm_err,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_dm,
  input  logic              halt,
  output logic              halted
);

  localparam int ST_W = $clog2(STARVE_MAX + 1);

  state_t          state;
  gnt_t            gnt;
  logic [ST_W-1:0] starve;
  logic            op_wr;
  logic            lat_tc;
  logic            misaligned;
  logic            busy;

`ifdef ALIGN_CHK_EN
  assign misaligned = dm_addr[0];
`else
  assign misaligned = 1'b0;
`endif

  assign busy = (state == IF_BUSY) || (state == DM_BUSY);

  // The done cycle is skipped: requesters still hold the just-completed request then.
  always_comb begin
    gnt = GNT_NONE;
    if (state == IDLE && !halt && !if_done && !dm_done)
      gnt = arb_pick(if_req, dm_req, starve < ST_W'(STARVE_MAX));
  end

  mem_arb_lat_cnt #(.MEM_LAT(MEM_LAT)) u_lat_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state == IDLE),
    .en    (busy),
    .tc    (lat_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      starve    <= '0;
      op_wr     <= 1'b0;
      if_rdata  <= '0;
      if_done   <= 1'b0;
      dm_rdata  <= '0;
      dm_done   <= 1'b0;
      dm_err    <= 1'b0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      halted    <= 1'b0;
    end else begin
      mem_en  <= 1'b0;
      mem_wr  <= 1'b0;
      if_done <= 1'b0;
      dm_done <= 1'b0;
      dm_err  <= 1'b0;

      if (!if_req || gnt == GNT_IF)
        starve <= '0;
      else if (gnt == GNT_DM && starve < ST_W'(STARVE_MAX))
        starve <= starve + 1'b1;

      case (state)
        IDLE: begin
          if (halt) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else if (gnt == GNT_DM) begin
            if (misaligned) begin
              dm_done <= 1'b1;
              dm_err  <= 1'b1;
            end else begin
              state     <= DM_BUSY;
              mem_en    <= 1'b1;
              mem_wr    <= dm_wr;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
              op_wr     <= dm_wr;
            end
          end else if (gnt == GNT_IF) begin
            state    <= IF_BUSY;
            mem_en   <= 1'b1;
            mem_addr <= if_addr;
            op_wr    <= 1'b0;
          end
        end
        IF_BUSY: begin
          if (lat_tc) begin
            if_rdata <= mem_rdata;
            if_done  <= 1'b1;
            state    <= IDLE;
          end
        end
        DM_BUSY: begin
          if (lat_tc) begin
            if (!op_wr) dm_rdata <= mem_rdata;
            dm_done <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state  <= HALTED;
          halted <= 1'b1;
        end
      endcase
    end
  end

  assign stall_if = if_req & ~if_done;
  assign stall_dm = dm_req & ~dm_done;

endmodule
